// File: rtl/rca_4stage_pl_if.sv
// Operand/result bundle for the 4-stage pipelined ripple-carry adder.
// The ovf signal exists only when RCA_4STAGE_PL_OVF_EN is defined.
interface rca_4stage_pl_if;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] s;
  logic       c_out;
`ifdef RCA_4STAGE_PL_OVF_EN
  logic       ovf;
`endif
  logic       out_valid;

`ifdef RCA_4STAGE_PL_OVF_EN
  modport master (output in_valid, a, b, cin, input s, c_out, ovf, out_valid);
  modport slave  (input in_valid, a, b, cin, output s, c_out, ovf, out_valid);
`else
  modport master (output in_valid, a, b, cin, input s, c_out, out_valid);
  modport slave  (input in_valid, a, b, cin, output s, c_out, out_valid);
`endif
endinterface

// File: rtl/rca_4stage_pl.sv
// 4-bit ripple-carry adder, one sum bit per pipeline stage, latency 4, 1/clk.
// Optional macro RCA_4STAGE_PL_OVF_EN adds a registered signed-overflow flag.
module rca_stage (
  input  logic clock,
  input  logic reset,
  input  logic a_bit,
  input  logic b_bit,
  input  logic c_in,
  output logic s_q,
  output logic c_q
);
  always_ff @(posedge clock) begin
    if (reset) begin
      s_q <= 1'b0;
      c_q <= 1'b0;
    end else begin
      s_q <= a_bit ^ b_bit ^ c_in;
      c_q <= (a_bit & b_bit) | (c_in & (a_bit ^ b_bit));
    end
  end
endmodule

module rca_4stage_pl (
  input logic            clock,
  input logic            reset,
  rca_4stage_pl_if.slave bus
);
  localparam int STAGES = 4;

  logic [STAGES-1:0] a_sk, b_sk;   // operand bits aligned to their stage
  logic [STAGES-1:0] c_chain;
  logic [STAGES-1:0] s_bit, c_bit;
  logic [STAGES-1:0] s_out;
  logic [STAGES:0]   vld_pipe;

  assign a_sk[0]    = bus.a[0];
  assign b_sk[0]    = bus.b[0];
  assign c_chain[0] = bus.cin;

  // Bit k waits k cycles so it meets the carry produced from the same operand set
  for (genvar k = 1; k < STAGES; k++) begin : g_skew
    logic [k-1:0] a_sr, b_sr;
    always_ff @(posedge clock) begin
      if (reset) begin
        a_sr <= '0;
        b_sr <= '0;
      end else begin
        a_sr[0] <= bus.a[k];
        b_sr[0] <= bus.b[k];
        for (int j = 1; j < k; j++) begin
          a_sr[j] <= a_sr[j-1];
          b_sr[j] <= b_sr[j-1];
        end
      end
    end
    assign a_sk[k]    = a_sr[k-1];
    assign b_sk[k]    = b_sr[k-1];
    assign c_chain[k] = c_bit[k-1];
  end

  rca_stage u_stage [STAGES-1:0] (
    .clock (clock),
    .reset (reset),
    .a_bit (a_sk),
    .b_bit (b_sk),
    .c_in  (c_chain),
    .s_q   (s_bit),
    .c_q   (c_bit)
  );

  // Early sum bits are held back so the whole word leaves with bit 3
  for (genvar k = 0; k < STAGES-1; k++) begin : g_deskew
    localparam int D = STAGES-1-k;
    logic [D-1:0] d_sr;
    always_ff @(posedge clock) begin
      if (reset) begin
        d_sr <= '0;
      end else begin
        d_sr[0] <= s_bit[k];
        for (int j = 1; j < D; j++) d_sr[j] <= d_sr[j-1];
      end
    end
    assign s_out[k] = d_sr[D-1];
  end
  assign s_out[STAGES-1] = s_bit[STAGES-1];

  assign vld_pipe[0] = bus.in_valid;
  always_ff @(posedge clock) begin
    if (reset) vld_pipe[STAGES:1] <= '0;
    else       vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

`ifdef RCA_4STAGE_PL_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it
  logic ovf_q;
  always_ff @(posedge clock) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= c_chain[STAGES-1] ^
                        ((a_sk[STAGES-1] & b_sk[STAGES-1]) |
                         (c_chain[STAGES-1] & (a_sk[STAGES-1] ^ b_sk[STAGES-1])));
  end
  assign bus.ovf = ovf_q;
`endif

  assign bus.s         = s_out;
  assign bus.c_out     = c_bit[STAGES-1];
  assign bus.out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_rca_4stage_pl.sv
// Directed-vector bench for rca_4stage_pl: back-to-back table, random stream
// with toggling valid, and reset in the middle of traffic.
module tb_rca_4stage_pl;
  logic clock = 1'b0;
  logic reset;
  int   n_pass = 0;
  int   n_total = 0;

  rca_4stage_pl_if bus ();
  rca_4stage_pl dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t tbl [7];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_out(input string name, input logic [3:0] s, input logic co,
                           input logic ov, input logic vld);
    check({name, ".s"}, int'(bus.s), int'(s));
    check({name, ".c_out"}, int'(bus.c_out), int'(co));
    check({name, ".out_valid"}, int'(bus.out_valid), int'(vld));
`ifdef RCA_4STAGE_PL_OVF_EN
    check({name, ".ovf"}, int'(bus.ovf), int'(ov));
`else
    if (ov) begin end
`endif
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic c);
    bus.in_valid = v;
    bus.a = a;
    bus.b = b;
    bus.cin = c;
  endtask

  logic [3:0] ra [8];
  logic [3:0] rb [8];
  logic       rc [8];
  logic       rv [8];

  initial begin
    tbl[0] = '{4'd4,  4'd2,  1'b0, 4'd6,  1'b0, 1'b0};
    tbl[1] = '{4'd10, 4'd3,  1'b1, 4'd14, 1'b0, 1'b0};
    tbl[2] = '{4'd15, 4'd1,  1'b0, 4'd0,  1'b1, 1'b0};
    tbl[3] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0};
    tbl[4] = '{4'd7,  4'd1,  1'b0, 4'd8,  1'b0, 1'b1};
    tbl[5] = '{4'd8,  4'd8,  1'b0, 4'd0,  1'b1, 1'b1};
    tbl[6] = '{4'd3,  4'd2,  1'b0, 4'd5,  1'b0, 1'b0};

    // Reset with live inputs: reset must win
    reset = 1'b1;
    drive(1'b1, 4'd9, 4'd9, 1'b1);
    step();
    step();
    check_out("reset", 4'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    step();
    step();
    step();
    step();
    check_out("post_reset_idle", 4'd0, 1'b0, 1'b0, 1'b0);

    // Back-to-back table; entry i comes out on step i+3
    for (int c = 0; c < 10; c++) begin
      if (c < 7) drive(1'b1, tbl[c].a, tbl[c].b, tbl[c].cin);
      else       drive(1'b0, 4'd0, 4'd0, 1'b0);
      step();
      if (c >= 3)
        check_out($sformatf("tbl%0d", c-3), tbl[c-3].s, tbl[c-3].co, tbl[c-3].ov, 1'b1);
      else if (c == 0)
        check("tbl_latency.out_valid", int'(bus.out_valid), 0);
    end

    // Random stream with in_valid toggling; reference is plain 5-bit addition
    for (int i = 0; i < 8; i++) begin
      ra[i] = 4'($urandom_range(0, 15));
      rb[i] = 4'($urandom_range(0, 15));
      rc[i] = 1'($urandom_range(0, 1));
      rv[i] = (i % 3) != 1;
    end
    for (int c = 0; c < 12; c++) begin
      if (c < 8) drive(rv[c], ra[c], rb[c], rc[c]);
      else       drive(1'b0, 4'd0, 4'd0, 1'b0);
      step();
      if (c >= 3 && c < 11) begin
        logic [4:0] sum;
        logic       ov;
        sum = {1'b0, ra[c-3]} + {1'b0, rb[c-3]} + {4'd0, rc[c-3]};
        ov  = (ra[c-3][3] == rb[c-3][3]) && (sum[3] != ra[c-3][3]);
        check_out($sformatf("rnd%0d", c-3), sum[3:0], sum[4], ov, rv[c-3]);
      end
    end
    check("rnd_drain.out_valid", int'(bus.out_valid), 0);

    // Three sets in flight, then reset: nothing stale may surface
    drive(1'b1, 4'd15, 4'd15, 1'b1); step();
    drive(1'b1, 4'd7,  4'd9,  1'b0); step();
    drive(1'b1, 4'd12, 4'd6,  1'b1); step();
    reset = 1'b1;
    drive(1'b1, 4'd15, 4'd15, 1'b1);
    step();
    check_out("midrst0", 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    check_out("midrst1", 4'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    drive(1'b1, 4'd5, 4'd6, 1'b0);
    step();
    check_out("after_rst1", 4'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    step();
    check_out("after_rst2", 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    check_out("after_rst3", 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    check_out("after_rst4", 4'd11, 1'b0, 1'b1, 1'b1);
    step();
    check_out("after_rst5", 4'd0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
